// File: rtl/subleq_abc_pkg.sv
// Shared state encoding for the ABC-variant SUBLEQ sequencer and control decoder.
// Both blocks import these constants so the 3-bit encoding cannot drift between them.
package subleq_abc_pkg;

  localparam logic [2:0] ST_FETCH_ABC    = 3'd0;
  localparam logic [2:0] ST_LOAD_ABC     = 3'd1;
  localparam logic [2:0] ST_FETCH_MEM_AB = 3'd2;
  localparam logic [2:0] ST_LOAD_MEM_AB  = 3'd3;
  localparam logic [2:0] ST_EXECUTE      = 3'd4;
  localparam logic [2:0] ST_WB_UPDATE_PC = 3'd5;
  localparam logic [2:0] ST_IDLE         = 3'd6;
  localparam logic [2:0] ST_HALT         = 3'd7;

  function automatic logic is_fetch(input logic [2:0] st);
    return (st == ST_FETCH_ABC) || (st == ST_FETCH_MEM_AB);
  endfunction

endpackage

// File: rtl/abc_wait_timer.sv
// Consecutive not-ready cycle counter for the fetch-state watchdog.
// expire fires on the TIMEOUT-th consecutive inc; TIMEOUT=0 disables it.
module abc_wait_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic expire
);

  localparam int W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0] LAST = W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (TIMEOUT > 0) && inc && (cnt_q == LAST);

endmodule

// File: rtl/subleq_seq_abc.sv
// Six-stage instruction-cycle sequencer with start/step/halt control,
// fetch watchdog and a saturating retired-instruction counter.
module subleq_seq_abc
  import subleq_abc_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              step_mode,
  input  logic              mem_ready,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic              zero,
  input  logic              negative,
  output logic [2:0]        state,
  output logic              running,
  output logic              halted,
  output logic              error,
  output logic [CNT_W-1:0]  instr_count
);

  logic [2:0]       state_q;
  logic [2:0]       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             err_q;
  logic             err_d;

  logic in_fetch;
  logic wait_clear;
  logic wait_inc;
  logic expire;

  assign in_fetch   = is_fetch(state_q);
  // Clearing outside fetch states covers the "clear on entry" behaviour.
  assign wait_clear = !in_fetch || mem_ready;
  assign wait_inc   = in_fetch && !mem_ready;

  abc_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (wait_clear),
    .inc    (wait_inc),
    .expire (expire)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FETCH_ABC;
      end
      ST_FETCH_ABC: begin
        if (mem_ready) begin
          state_d = ST_LOAD_ABC;
        end else if (expire) begin
          state_d = ST_HALT;
          err_d   = 1'b1;
        end
      end
      ST_LOAD_ABC:     state_d = ST_FETCH_MEM_AB;
      ST_FETCH_MEM_AB: begin
        if (mem_ready) begin
          state_d = ST_LOAD_MEM_AB;
        end else if (expire) begin
          state_d = ST_HALT;
          err_d   = 1'b1;
        end
      end
      ST_LOAD_MEM_AB:  state_d = ST_EXECUTE;
      ST_EXECUTE:      state_d = ST_WB_UPDATE_PC;
      ST_WB_UPDATE_PC: begin
        if (!(&cnt_q)) cnt_d = cnt_q + CNT_W'(1);
        // A taken branch to the all-ones address is the self-loop halt idiom.
        if ((zero || negative) && (&c_addr)) begin
          state_d = ST_HALT;
        end else if (step_mode) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_FETCH_ABC;
        end
      end
      ST_HALT:         state_d = ST_HALT;
      default:         state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign state       = state_q;
  assign running     = (state_q < ST_IDLE);
  assign halted      = (state_q == ST_HALT);
  assign error       = err_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_subleq_seq_abc.sv
// Directed-vector bench for subleq_seq_abc (TIMEOUT=4, CNT_W=4 to reach the
// watchdog and counter-saturation corners quickly).
module tb_subleq_seq_abc;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       step_mode;
  logic       mem_ready;
  logic [7:0] c_addr;
  logic       zero;
  logic       negative;
  logic [2:0] state;
  logic       running;
  logic       halted;
  logic       error;
  logic [3:0] instr_count;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  subleq_seq_abc #(
    .ADDR_W  (8),
    .CNT_W   (4),
    .TIMEOUT (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .step_mode   (step_mode),
    .mem_ready   (mem_ready),
    .c_addr      (c_addr),
    .zero        (zero),
    .negative    (negative),
    .state       (state),
    .running     (running),
    .halted      (halted),
    .error       (error),
    .instr_count (instr_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk_st(input string tag, input logic [31:0] exp);
    chk(tag, 32'(state), exp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  int t0;
  logic [31:0] seq [6] = '{1, 2, 3, 4, 5, 0};

  initial begin
    rst = 1'b1; start = 1'b0; step_mode = 1'b0; mem_ready = 1'b1;
    c_addr = 8'h00; zero = 1'b0; negative = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk_st("rst_state", 6);
    chk("rst_running", 32'(running), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_count", 32'(instr_count), 0);

    // Idle holds without start
    tick();
    chk_st("idle_hold", 6);

    // Basic sequence with mem_ready high
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_st("start_to_fetch", 0);
    chk("fetch_running", 32'(running), 1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_st("seq", seq[i]);
    end
    chk("count_after_1", 32'(instr_count), 1);

    // Stalls: 3 cycles in FETCH_ABC, 2 in FETCH_MEM_AB -> 11 cycles
    t0 = cyc;
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_st("stall_abc", 0);
    end
    mem_ready = 1'b1;
    tick(); chk_st("stall_to_load", 1);
    tick(); chk_st("stall_to_fmem", 2);
    mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_st("stall_mem", 2);
    end
    mem_ready = 1'b1;
    for (int i = 2; i < 6; i++) begin
      tick();
      chk_st("stall_tail", seq[i]);
    end
    chk("stall_cycles", 32'(cyc - t0), 11);
    chk("stall_error", 32'(error), 0);
    chk("count_after_2", 32'(instr_count), 2);

    // Watchdog expiry in FETCH_MEM_AB
    tick(); tick();
    chk_st("wd_in_fmem", 2);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_st("wd_wait", 2);
    end
    tick();
    chk_st("wd_halt", 7);
    chk("wd_error", 32'(error), 1);
    chk("wd_running", 32'(running), 0);
    chk("wd_halted", 32'(halted), 1);
    mem_ready = 1'b1;
    do_reset();
    chk_st("wd_rst_state", 6);
    chk("wd_rst_error", 32'(error), 0);
    chk("wd_rst_count", 32'(instr_count), 0);

    // mem_ready on the 4th cycle wins over expiry
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    chk_st("wd2_in_fmem", 2);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk_st("wd2_wait", 2);
    mem_ready = 1'b1;
    tick();
    chk_st("wd2_advance", 3);
    chk("wd2_error", 32'(error), 0);
    tick(); tick(); tick();
    chk_st("wd2_done", 0);
    chk("wd2_count", 32'(instr_count), 1);

    // Halt on taken branch to all-ones
    tick(); tick(); tick(); tick();
    chk_st("h_exec", 4);
    c_addr = 8'hFF; negative = 1'b1;
    tick();
    chk_st("h_wb", 5);
    tick();
    chk_st("h_halt", 7);
    chk("h_count", 32'(instr_count), 2);
    chk("h_error", 32'(error), 0);
    start = 1'b1;
    tick(); tick(); tick();
    chk_st("h_start_ignored", 7);
    start = 1'b0;
    do_reset();
    chk_st("h_rst_state", 6);
    chk("h_rst_count", 32'(instr_count), 0);
    chk("h_rst_error", 32'(error), 0);
    negative = 1'b0;

    // c_addr all-ones without flags: no halt
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk_st("nohalt_cont", 0);
    chk("nohalt_count", 32'(instr_count), 1);

    // Single-step mode
    step_mode = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk_st("step_idle", 6);
    tick(); tick();
    chk_st("step_wait", 6);
    start = 1'b1; tick(); start = 1'b0;
    chk_st("step_restart", 0);
    for (int i = 0; i < 6; i++) tick();
    chk_st("step_idle2", 6);
    chk("step_count", 32'(instr_count), 3);
    step_mode = 1'b0;
    c_addr = 8'h00;

    // Counter saturation over 20 instructions
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 90; i++) tick();
    chk("sat_mid", 32'(instr_count), 15);
    for (int i = 0; i < 30; i++) tick();
    chk_st("sat_state", 0);
    chk("sat_count", 32'(instr_count), 15);

    // Reset during EXECUTE
    tick(); tick(); tick(); tick();
    chk_st("rx_exec", 4);
    do_reset();
    chk_st("rx_state", 6);
    chk("rx_count", 32'(instr_count), 0);
    chk("rx_running", 32'(running), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/subleq_seq_abc.md
# subleq_seq_abc

State sequencer for the ABC-variant SUBLEQ core. It generates the 3-bit `state` consumed by the control decoder, which turns it into register/memory/PC enables. It advances through the six-stage instruction cycle and stalls fetch states on a memory-ready handshake. It also provides start, single-step, halt-on-self-branch and a memory-timeout watchdog, plus a retired-instruction counter.

## Interface
Parameters:
- `ADDR_W`, 8, width of the C operand / PC address
- `CNT_W`, 16, width of the retired-instruction counter
- `TIMEOUT`, 64, max consecutive not-ready cycles in a fetch state; 0 disables the watchdog

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  level; sampled only in IDLE
- `step_mode`  in  1  1 = return to IDLE after every retired instruction
- `mem_ready`  in  1  memory read data valid in FETCH_ABC / FETCH_MEM_AB
- `c_addr`  in  ADDR_W  current C operand (branch target) from the abc register
- `zero`  in  1  ALU zero flag
- `negative`  in  1  ALU negative flag
- `state`  out  3  current state, encoding below
- `running`  out  1  state ≤ 5
- `halted`  out  1  state == HALT
- `error`  out  1  sticky; set on watchdog expiry
- `instr_count`  out  CNT_W  retired instructions, saturating

## Operation
- Encoding: FETCH_ABC=0, LOAD_ABC=1, FETCH_MEM_AB=2, LOAD_MEM_AB=3, EXECUTE=4, WRITEBACK_UPDATE_PC=5, IDLE=6, HALT=7. The control decoder drives no enables in 6 and 7.
- Reset values: state=IDLE, running=0, halted=0, error=0, instr_count=0, internal wait counter=0.
- IDLE: `start`=1 → FETCH_ABC. Otherwise stay in IDLE.
- FETCH_ABC: `mem_ready`=1 → LOAD_ABC. Otherwise stay in FETCH_ABC.
- FETCH_MEM_AB: `mem_ready`=1 → LOAD_MEM_AB. Otherwise stay in FETCH_MEM_AB.
- LOAD_ABC → FETCH_MEM_AB, LOAD_MEM_AB → EXECUTE, EXECUTE → WRITEBACK_UPDATE_PC. All three are unconditional.
- WRITEBACK_UPDATE_PC:
  - instr_count += 1, saturating at all-ones.
  - If (`zero`|`negative`) and `c_addr` == all-ones → HALT.
  - Else if `step_mode` → IDLE.
  - Else → FETCH_ABC.
- HALT: absorbing state. Only `rst` exits it. `start` is ignored.
- `start` outside IDLE is ignored. `step_mode` is sampled only in WRITEBACK_UPDATE_PC.
- Watchdog (TIMEOUT>0):
  - The wait counter clears on entry to either fetch state and whenever `mem_ready`=1.
  - It increments on each fetch-state cycle with `mem_ready`=0.
  - When a not-ready cycle would be the TIMEOUT-th consecutive one, next state = HALT and `error` sets.
  - `mem_ready`=1 on that same cycle wins: normal advance, no error.
- Halt condition uses the flags present during WRITEBACK_UPDATE_PC, the same cycle the decoder asserts write/PC enables. The final write is therefore still performed.

## Timing
- Fully registered `state`. `running`/`halted` decode from the `state` register, so they carry no combinational path from inputs.
- With `mem_ready` tied high, one instruction takes 6 cycles.
- Back-to-back instructions: WRITEBACK_UPDATE_PC is followed directly by FETCH_ABC, giving 6 cycles per instruction.
- Each not-ready cycle adds exactly one cycle to the fetch state.
- IDLE to FETCH_ABC: 1 cycle after `start` is sampled high.
- instr_count updates on the edge leaving WRITEBACK_UPDATE_PC, including the halting instruction.
- `rst` mid-instruction: the next state is IDLE, counters are cleared and `error` is cleared. No partial instruction completes.

## Structure
- Shared package `subleq_abc_pkg`: the 3-bit state localparams (0–7), used by both this block and the control decoder so encodings cannot drift.
- One sub-module, `abc_wait_timer`:
  - Holds the clearable counter, with `clear`, `inc` and an `expire` output when count == TIMEOUT-1 and `inc` is asserted.
  - TIMEOUT=0 ties `expire` low.
- Top level holds the next-state logic and the saturating instr_count.

## Test plan
- Reset, `start`=1, `mem_ready`=1, flags 0, step_mode=0 → state sequence 6,0,1,2,3,4,5,0,…; instr_count=1 after first 5→0 edge.
- `mem_ready` low for 3 cycles in FETCH_ABC, then low for 2 cycles in FETCH_MEM_AB → instruction takes 11 cycles; error=0.
- TIMEOUT=4, `mem_ready` held 0 in FETCH_MEM_AB → exactly 4 cycles in state 2, then 7; error=1, running=0. Repeat with `mem_ready`=1 on the 4th cycle → advances to 3, error=0.
- `c_addr`=8'hFF, `negative`=1 in state 5 → HALT; `start` pulses ignored; `rst` → IDLE, instr_count=0, error=0.
- `c_addr`=8'hFF with zero=negative=0 → no halt, continues to 0. With step_mode=1 → returns to 6 after each instruction and waits for `start`.
- CNT_W=4, run 20 instructions → instr_count saturates at 15. `rst` asserted during EXECUTE → next state 6.
